sha256_compress: RTL

//  - Iterative SHA-256 compression core: one 512-bit block in 64 rounds, one round per clock.
//  - Direct consumer of the existing combinational sigma_0 (Sigma0: ROTR2^ROTR13^ROTR22) stage,

---
 rtl/sha256_defs.sv | 33 +++
 rtl/sha256_k_rom.sv | 9 +
 rtl/sigma_0.sv | 7 +
 rtl/sigma_1.sv | 7 +
 rtl/sha256_compress.sv | 97 +++++++++
 5 files changed

// File: rtl/sha256_defs.sv
// Shared SHA-256 definitions: round constants, initial hash value, FSM encoding
// and a helper that picks one 32-bit word out of a 256-bit chaining value.
package sha256_defs;
  localparam int DATA_WIDTH = 32;
  localparam int ROUNDS     = 64;

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  localparam word_t SHA256_K [0:ROUNDS-1] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [8*DATA_WIDTH-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  // Word 0 (H0 / a) lives in the most significant 32 bits of the bus.
  function automatic word_t word_sel(input logic [8*DATA_WIDTH-1:0] bus, input logic [2:0] idx);
    return bus[8*DATA_WIDTH-1 - DATA_WIDTH*int'(idx) -: DATA_WIDTH];
  endfunction
endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant ROM addressed by the round counter.
module sha256_k_rom
  import sha256_defs::*;
(
  input  logic [5:0] addr_i,
  output word_t      k_o
);
  assign k_o = SHA256_K[addr_i];
endmodule

// File: rtl/sigma_0.sv
// SHA-256 big Sigma0 on the a word: ROTR2 ^ ROTR13 ^ ROTR22.
module sigma_0 (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  assign y_o = {x_i[1:0], x_i[31:2]} ^ {x_i[12:0], x_i[31:13]} ^ {x_i[21:0], x_i[31:22]};
endmodule

// File: rtl/sigma_1.sv
// SHA-256 big Sigma1 on the e word: ROTR6 ^ ROTR11 ^ ROTR25.
module sigma_1 (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  assign y_o = {x_i[5:0], x_i[31:6]} ^ {x_i[10:0], x_i[31:11]} ^ {x_i[24:0], x_i[31:25]};
endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: one round per accepted W_t, final feed-forward add,
// one-cycle done pulse with the updated chaining value held on hash_out.
module sha256_compress
  import sha256_defs::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] hash_in,
  input  logic         w_valid,
  input  logic [31:0]  w_data,
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out,
  output logic [1:0]   dbg_state
);
  // Handshake: in ROUND, w_ready is 1 regardless of w_valid; a word W_t is consumed
  // on each rising edge where w_valid && w_ready. w_ready is 0 in IDLE and FINAL.
  state_t       state_q, state_d;
  logic [5:0]   t_q;
  word_t        a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [255:0] hsave_q, hash_q;
  logic         done_q;
  word_t        k_t, s0_a, s1_e, ch_efg, maj_abc, t1, t2, a_d, e_d;

  sha256_k_rom u_k_rom (.addr_i(t_q), .k_o(k_t));
  sigma_0 u_sigma_0 (.x_i(a_q), .y_o(s0_a));
  sigma_1 u_sigma_1 (.x_i(e_q), .y_o(s1_e));

  assign ch_efg  = (e_q & f_q) ^ (~e_q & g_q);
  assign maj_abc = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
  assign t1      = h_q + s1_e + ch_efg + k_t + w_data;
  assign t2      = s0_a + maj_abc;
  assign a_d     = t1 + t2;
  assign e_d     = d_q + t1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ROUND;
      ST_ROUND: if (w_valid && t_q == 6'(ROUNDS - 1)) state_d = ST_FINAL;
      ST_FINAL: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = (state_q == ST_ROUND);
    busy    = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
      hsave_q <= '0;
      hash_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          hsave_q <= hash_in;
          a_q <= word_sel(hash_in, 3'd0); b_q <= word_sel(hash_in, 3'd1);
          c_q <= word_sel(hash_in, 3'd2); d_q <= word_sel(hash_in, 3'd3);
          e_q <= word_sel(hash_in, 3'd4); f_q <= word_sel(hash_in, 3'd5);
          g_q <= word_sel(hash_in, 3'd6); h_q <= word_sel(hash_in, 3'd7);
          t_q <= '0;
        end
        ST_ROUND: if (w_valid) begin
          h_q <= g_q; g_q <= f_q; f_q <= e_q; e_q <= e_d;
          d_q <= c_q; c_q <= b_q; b_q <= a_q; a_q <= a_d;
          t_q <= t_q + 6'd1;
        end
        ST_FINAL: begin
          hash_q <= {word_sel(hsave_q, 3'd0) + a_q, word_sel(hsave_q, 3'd1) + b_q,
                     word_sel(hsave_q, 3'd2) + c_q, word_sel(hsave_q, 3'd3) + d_q,
                     word_sel(hsave_q, 3'd4) + e_q, word_sel(hsave_q, 3'd5) + f_q,
                     word_sel(hsave_q, 3'd6) + g_q, word_sel(hsave_q, 3'd7) + h_q};
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign hash_out  = hash_q;
  assign dbg_state = state_q;
endmodule
